// File: rtl/sb_pkg.sv
// Shared types and helpers for the long-latency scoreboard.
// Register-file geometry, one-hot decode and removal counting.
package sb_pkg;

  localparam int REG_IDX_W = 5;
  localparam int REG_NUM   = 32;
  localparam int MAX_ENTRY = 16;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  function automatic logic [REG_NUM-1:0] onehot32(input reg_idx_t idx);
    logic [REG_NUM-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  function automatic logic [4:0] popcount(input logic [MAX_ENTRY-1:0] vec);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < MAX_ENTRY; i++) begin
      c = c + {4'd0, vec[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/sb_alloc_pick.sv
// Lowest-index free-entry picker: one-hot grant over ~valid plus any_free.
// Fixed priority keeps allocation deterministic and easy to predict.
module sb_alloc_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] valid,
  output logic [N-1:0] grant,
  output logic         any_free
);

  logic [N-1:0] free_vec;
  logic         found;

  assign free_vec = ~valid;
  assign any_free = |free_vec;

  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (free_vec[i] && !found) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lat_scoreboard.sv
// Long-latency destination scoreboard: RAW/WAW stall detection, entry allocation
// on long writes, and retirement from multiple writeback ports.
module lat_scoreboard
  import sb_pkg::*;
#(
  parameter int NUM_ENTRY = 4,
  parameter int NUM_WB    = 2,
  parameter int WB_BYPASS = 1,
  parameter int CNT_W     = $clog2(NUM_ENTRY + 1)
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        instruction_vaild,
  input  logic [REG_IDX_W-1:0]        rs1_index,
  input  logic [REG_IDX_W-1:0]        rs2_index,
  input  logic [REG_IDX_W-1:0]        rd_index,
  input  logic                        rs1_mark,
  input  logic                        rs2_mark,
  input  logic                        rd_mark,
  input  logic                        rd_long_mark,
  input  logic                        MEM_flush,
  input  logic [NUM_WB-1:0]           wb_valid,
  input  logic [REG_IDX_W*NUM_WB-1:0] wb_rd,
  output logic                        conflict,
  output logic                        full,
  output logic [CNT_W-1:0]            occupancy,
  output logic [REG_NUM-1:0]          pending
);

  localparam logic BYPASS_EN = (WB_BYPASS != 0);

  logic [NUM_ENTRY-1:0] ent_valid;
  reg_idx_t             ent_rd [NUM_ENTRY];
  logic [CNT_W-1:0]     occ_q;
  logic                 full_q;

  logic hit_rs1, hit_rs2, hit_rd;
  logic wbhit_rs1, wbhit_rs2, wbhit_rd;
  logic eff_rs1, eff_rs2, eff_rd;

  logic [NUM_ENTRY-1:0] remove_vec;
  logic [MAX_ENTRY-1:0] remove_pad;
  logic [4:0]           rm_cnt;

  logic [NUM_ENTRY-1:0] grant;
  logic                 any_free;
  logic                 alloc_req;
  logic                 alloc;
  logic [NUM_ENTRY-1:0] alloc_vec;
  logic [CNT_W-1:0]     occ_next;

  // x0 is architecturally constant, so it can never be a tracked hazard.
  always_comb begin
    hit_rs1 = 1'b0;
    hit_rs2 = 1'b0;
    hit_rd  = 1'b0;
    for (int e = 0; e < NUM_ENTRY; e++) begin
      if (ent_valid[e]) begin
        if (ent_rd[e] == rs1_index) hit_rs1 = 1'b1;
        if (ent_rd[e] == rs2_index) hit_rs2 = 1'b1;
        if (ent_rd[e] == rd_index)  hit_rd  = 1'b1;
      end
    end
    hit_rs1 = hit_rs1 & (rs1_index != '0);
    hit_rs2 = hit_rs2 & (rs2_index != '0);
    hit_rd  = hit_rd  & (rd_index  != '0);
  end

  always_comb begin
    wbhit_rs1 = 1'b0;
    wbhit_rs2 = 1'b0;
    wbhit_rd  = 1'b0;
    for (int k = 0; k < NUM_WB; k++) begin
      if (wb_valid[k]) begin
        if (wb_rd[k*REG_IDX_W +: REG_IDX_W] == rs1_index) wbhit_rs1 = 1'b1;
        if (wb_rd[k*REG_IDX_W +: REG_IDX_W] == rs2_index) wbhit_rs2 = 1'b1;
        if (wb_rd[k*REG_IDX_W +: REG_IDX_W] == rd_index)  wbhit_rd  = 1'b1;
      end
    end
  end

  assign eff_rs1 = hit_rs1 & ~(BYPASS_EN & wbhit_rs1);
  assign eff_rs2 = hit_rs2 & ~(BYPASS_EN & wbhit_rs2);
  assign eff_rd  = hit_rd  & ~(BYPASS_EN & wbhit_rd);

  assign conflict = instruction_vaild &
                    ((rs1_mark & eff_rs1) | (rs2_mark & eff_rs2) |
                     (rd_mark & eff_rd) | (rd_long_mark & full_q));

  // Every entry matching any writeback retires, even if duplicates ever existed.
  always_comb begin
    remove_vec = '0;
    for (int e = 0; e < NUM_ENTRY; e++) begin
      for (int k = 0; k < NUM_WB; k++) begin
        if (ent_valid[e] && wb_valid[k] &&
            (wb_rd[k*REG_IDX_W +: REG_IDX_W] == ent_rd[e])) begin
          remove_vec[e] = 1'b1;
        end
      end
    end
    remove_pad                = '0;
    remove_pad[NUM_ENTRY-1:0] = remove_vec;
  end

  assign rm_cnt = popcount(remove_pad);

  sb_alloc_pick #(
    .N(NUM_ENTRY)
  ) u_pick (
    .valid   (ent_valid),
    .grant   (grant),
    .any_free(any_free)
  );

  assign alloc_req = instruction_vaild & rd_long_mark & rd_mark &
                     (rd_index != '0) & ~conflict & ~MEM_flush;
  assign alloc     = alloc_req & any_free;
  assign alloc_vec = grant & {NUM_ENTRY{alloc}};
  assign occ_next  = occ_q + CNT_W'(alloc) - CNT_W'(rm_cnt);

  // A granted entry is free, so it can never also be retiring this cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ent_valid <= '0;
      for (int e = 0; e < NUM_ENTRY; e++) begin
        ent_rd[e] <= '0;
      end
      occ_q  <= '0;
      full_q <= 1'b0;
    end else begin
      for (int e = 0; e < NUM_ENTRY; e++) begin
        if (alloc_vec[e]) begin
          ent_valid[e] <= 1'b1;
          ent_rd[e]    <= rd_index;
        end else if (remove_vec[e]) begin
          ent_valid[e] <= 1'b0;
        end
      end
      occ_q  <= occ_next;
      full_q <= (occ_next == CNT_W'(NUM_ENTRY));
    end
  end

  always_comb begin
    pending = '0;
    for (int e = 0; e < NUM_ENTRY; e++) begin
      if (ent_valid[e]) pending = pending | onehot32(ent_rd[e]);
    end
    pending[0] = 1'b0;
  end

  assign occupancy = occ_q;
  assign full      = full_q;

endmodule

// File: tb/tb_lat_scoreboard.sv
// Scoreboard bench for lat_scoreboard: a behavioural entry model predicts conflict
// and post-edge state; expected/observed snapshots are queued and compared per scenario.
module tb_lat_scoreboard;

  localparam int NE = 4;
  localparam int NW = 2;
  localparam int CW = 3;

  logic          clk;
  logic          rstn;
  logic          instruction_vaild;
  logic [4:0]    rs1_index, rs2_index, rd_index;
  logic          rs1_mark, rs2_mark, rd_mark, rd_long_mark, MEM_flush;
  logic [NW-1:0] wb_valid;
  logic [5*NW-1:0] wb_rd;
  logic          conflict;
  logic          full;
  logic [CW-1:0] occupancy;
  logic [31:0]   pending;

  lat_scoreboard #(
    .NUM_ENTRY(NE),
    .NUM_WB   (NW),
    .WB_BYPASS(1),
    .CNT_W    (CW)
  ) dut (
    .clk              (clk),
    .rstn             (rstn),
    .instruction_vaild(instruction_vaild),
    .rs1_index        (rs1_index),
    .rs2_index        (rs2_index),
    .rd_index         (rd_index),
    .rs1_mark         (rs1_mark),
    .rs2_mark         (rs2_mark),
    .rd_mark          (rd_mark),
    .rd_long_mark     (rd_long_mark),
    .MEM_flush        (MEM_flush),
    .wb_valid         (wb_valid),
    .wb_rd            (wb_rd),
    .conflict         (conflict),
    .full             (full),
    .occupancy        (occupancy),
    .pending          (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [CW-1:0] occ;
    logic          full;
    logic [31:0]   pend;
  } snap_t;

  snap_t exp_q[$];
  snap_t obs_q[$];
  int    n_checks;
  int    n_pass;

  bit m_valid [NE];
  int m_rd    [NE];

  function automatic bit m_wbhit(input int x);
    for (int k = 0; k < NW; k++) begin
      if (wb_valid[k] && (int'(wb_rd[k*5 +: 5]) == x)) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic bit m_hit(input int x);
    if (x == 0) return 1'b0;
    for (int e = 0; e < NE; e++) begin
      if (m_valid[e] && m_rd[e] == x) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic int m_occ();
    int c = 0;
    for (int e = 0; e < NE; e++) if (m_valid[e]) c++;
    return c;
  endfunction

  function automatic logic [31:0] m_pending();
    logic [31:0] p = '0;
    for (int e = 0; e < NE; e++) if (m_valid[e]) p[m_rd[e]] = 1'b1;
    return p;
  endfunction

  function automatic bit m_conflict();
    bit h1, h2, h3;
    h1 = m_hit(int'(rs1_index)) && !m_wbhit(int'(rs1_index));
    h2 = m_hit(int'(rs2_index)) && !m_wbhit(int'(rs2_index));
    h3 = m_hit(int'(rd_index))  && !m_wbhit(int'(rd_index));
    return instruction_vaild && ((rs1_mark && h1) || (rs2_mark && h2) ||
                                 (rd_mark && h3) || (rd_long_mark && m_occ() == NE));
  endfunction

  function automatic void m_clear();
    for (int e = 0; e < NE; e++) begin
      m_valid[e] = 1'b0;
      m_rd[e]    = 0;
    end
  endfunction

  task automatic applyStimulus(input bit iv, input int rs1, input int rs2, input int rd,
                               input bit r1m, input bit r2m, input bit rdm,
                               input bit lng, input bit flush);
    instruction_vaild = iv;
    rs1_index         = rs1[4:0];
    rs2_index         = rs2[4:0];
    rd_index          = rd[4:0];
    rs1_mark          = r1m;
    rs2_mark          = r2m;
    rd_mark           = rdm;
    rd_long_mark      = lng;
    MEM_flush         = flush;
  endtask

  task automatic set_wb(input bit v0, input int r0, input bit v1, input int r1);
    wb_valid    = {v1, v0};
    wb_rd[4:0]  = r0[4:0];
    wb_rd[9:5]  = r1[4:0];
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_wb(0, 0, 0, 0);
  endtask

  // One clock edge: update the model from pre-edge decisions, queue expected and observed state.
  task automatic tick();
    bit    do_alloc;
    int    slot;
    bit    rm [NE];
    snap_t s;
    do_alloc = instruction_vaild && rd_long_mark && rd_mark && (rd_index != 0) &&
               !m_conflict() && !MEM_flush;
    slot = -1;
    for (int e = 0; e < NE; e++) if (!m_valid[e] && slot < 0) slot = e;
    for (int e = 0; e < NE; e++) rm[e] = m_valid[e] && m_wbhit(m_rd[e]);
    @(posedge clk);
    if (rstn) begin
      for (int e = 0; e < NE; e++) if (rm[e]) m_valid[e] = 1'b0;
      if (do_alloc && slot >= 0) begin
        m_valid[slot] = 1'b1;
        m_rd[slot]    = int'(rd_index);
      end
    end
    s.occ  = CW'(m_occ());
    s.full = (m_occ() == NE);
    s.pend = m_pending();
    exp_q.push_back(s);
    #1;
    s.occ  = occupancy;
    s.full = full;
    s.pend = pending;
    obs_q.push_back(s);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    idle();
    m_clear();
    #12;
    n_checks++;
    if (conflict !== 1'b0 || full !== 1'b0 || occupancy !== '0 || pending !== '0)
      $display("[TB] FAIL reset_outputs: got c=%b f=%b occ=%0d pend=%h want all zero",
               conflict, full, occupancy, pending);
    else n_pass++;
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_raw();
    snap_t e, o;
    applyStimulus(1, 0, 0, 5, 0, 0, 1, 1, 0);
    #1;
    n_checks++;
    if (conflict !== m_conflict()) $display("[TB] FAIL raw_mul: got %b want %b", conflict, m_conflict());
    else n_pass++;
    tick();
    applyStimulus(1, 5, 0, 6, 1, 0, 1, 0, 0);
    #1;
    n_checks++;
    if (conflict !== 1'b1) $display("[TB] FAIL raw_stall: got %b want 1", conflict);
    else n_pass++;
    tick();
    set_wb(1, 5, 0, 0);
    #1;
    n_checks++;
    if (conflict !== 1'b0) $display("[TB] FAIL raw_bypass: got %b want 0", conflict);
    else n_pass++;
    tick();
    idle();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_checks++;
      if (o.occ !== e.occ || o.full !== e.full || o.pend !== e.pend)
        $display("[TB] FAIL raw_state: got occ=%0d full=%b pend=%h want occ=%0d full=%b pend=%h",
                 o.occ, o.full, o.pend, e.occ, e.full, e.pend);
      else n_pass++;
    end
  endtask

  task automatic test_full();
    snap_t e, o;
    for (int r = 1; r <= 4; r++) begin
      applyStimulus(1, 0, 0, r, 0, 0, 1, 1, 0);
      #1;
      n_checks++;
      if (conflict !== m_conflict()) $display("[TB] FAIL full_fill%0d: got %b want %b", r, conflict, m_conflict());
      else n_pass++;
      tick();
    end
    applyStimulus(1, 0, 0, 7, 0, 0, 1, 1, 0);
    #1;
    n_checks++;
    if (conflict !== 1'b1 || full !== 1'b1) $display("[TB] FAIL full_stall: got c=%b f=%b want 1 1", conflict, full);
    else n_pass++;
    tick();
    set_wb(0, 0, 1, 3);
    #1;
    tick();
    set_wb(0, 0, 0, 0);
    #1;
    n_checks++;
    if (conflict !== 1'b0 || full !== 1'b0) $display("[TB] FAIL full_release: got c=%b f=%b want 0 0", conflict, full);
    else n_pass++;
    tick();
    n_checks++;
    if (dut.ent_valid[2] !== 1'b1 || dut.ent_rd[2] !== 5'd7)
      $display("[TB] FAIL full_slot2: got v=%b rd=%0d want v=1 rd=7", dut.ent_valid[2], dut.ent_rd[2]);
    else n_pass++;
    idle();
    set_wb(1, 1, 1, 2);
    tick();
    set_wb(1, 4, 1, 7);
    tick();
    idle();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_checks++;
      if (o.occ !== e.occ || o.full !== e.full || o.pend !== e.pend)
        $display("[TB] FAIL full_state: got occ=%0d full=%b pend=%h want occ=%0d full=%b pend=%h",
                 o.occ, o.full, o.pend, e.occ, e.full, e.pend);
      else n_pass++;
    end
  endtask

  task automatic test_x0();
    snap_t e, o;
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 1, 0);
    #1;
    n_checks++;
    if (conflict !== 1'b0) $display("[TB] FAIL x0_write: got %b want 0", conflict);
    else n_pass++;
    tick();
    applyStimulus(1, 0, 0, 12, 1, 1, 1, 0, 0);
    #1;
    n_checks++;
    if (conflict !== 1'b0) $display("[TB] FAIL x0_read: got %b want 0", conflict);
    else n_pass++;
    tick();
    idle();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_checks++;
      if (o.occ !== e.occ || o.full !== e.full || o.pend !== e.pend)
        $display("[TB] FAIL x0_state: got occ=%0d full=%b pend=%h want occ=%0d full=%b pend=%h",
                 o.occ, o.full, o.pend, e.occ, e.full, e.pend);
      else n_pass++;
    end
  endtask

  task automatic test_waw();
    snap_t e, o;
    applyStimulus(1, 0, 0, 9, 0, 0, 1, 1, 0);
    tick();
    #1;
    n_checks++;
    if (conflict !== 1'b1) $display("[TB] FAIL waw_stall: got %b want 1", conflict);
    else n_pass++;
    tick();
    set_wb(1, 9, 0, 0);
    #1;
    n_checks++;
    if (conflict !== 1'b0) $display("[TB] FAIL waw_bypass: got %b want 0", conflict);
    else n_pass++;
    tick();
    idle();
    n_checks++;
    if (occupancy !== 3'd1 || pending !== 32'h0000_0200)
      $display("[TB] FAIL waw_realloc: got occ=%0d pend=%h want occ=1 pend=00000200", occupancy, pending);
    else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_checks++;
      if (o.occ !== e.occ || o.full !== e.full || o.pend !== e.pend)
        $display("[TB] FAIL waw_state: got occ=%0d full=%b pend=%h want occ=%0d full=%b pend=%h",
                 o.occ, o.full, o.pend, e.occ, e.full, e.pend);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    snap_t e, o;
    applyStimulus(1, 0, 0, 2, 0, 0, 1, 1, 0);
    tick();
    applyStimulus(1, 0, 0, 4, 0, 0, 1, 1, 0);
    tick();
    applyStimulus(1, 0, 0, 8, 0, 0, 1, 1, 0);
    set_wb(1, 2, 1, 4);
    #1;
    n_checks++;
    if (conflict !== m_conflict()) $display("[TB] FAIL b2b_alloc: got %b want %b", conflict, m_conflict());
    else n_pass++;
    tick();
    n_checks++;
    if (occupancy !== 3'd2 || pending !== 32'h0000_0300)
      $display("[TB] FAIL b2b_dual_wb: got occ=%0d pend=%h want occ=2 pend=00000300", occupancy, pending);
    else n_pass++;
    idle();
    set_wb(1, 11, 0, 0);
    tick();
    set_wb(1, 9, 1, 8);
    tick();
    idle();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_checks++;
      if (o.occ !== e.occ || o.full !== e.full || o.pend !== e.pend)
        $display("[TB] FAIL b2b_state: got occ=%0d full=%b pend=%h want occ=%0d full=%b pend=%h",
                 o.occ, o.full, o.pend, e.occ, e.full, e.pend);
      else n_pass++;
    end
  endtask

  task automatic test_flush_and_reset();
    snap_t e, o;
    applyStimulus(1, 0, 0, 10, 0, 0, 1, 1, 1);
    #1;
    n_checks++;
    if (conflict !== 1'b0) $display("[TB] FAIL flush_conflict: got %b want 0", conflict);
    else n_pass++;
    tick();
    for (int r = 1; r <= 4; r++) begin
      applyStimulus(1, 0, 0, r + 20, 0, 0, 1, 1, 0);
      tick();
    end
    idle();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_checks++;
      if (o.occ !== e.occ || o.full !== e.full || o.pend !== e.pend)
        $display("[TB] FAIL flush_state: got occ=%0d full=%b pend=%h want occ=%0d full=%b pend=%h",
                 o.occ, o.full, o.pend, e.occ, e.full, e.pend);
      else n_pass++;
    end
    applyStimulus(1, 21, 0, 3, 1, 0, 1, 1, 0);
    #2;
    rstn = 1'b0;
    m_clear();
    #1;
    n_checks++;
    if (conflict !== 1'b0 || full !== 1'b0 || occupancy !== '0 || pending !== '0)
      $display("[TB] FAIL async_reset: got c=%b f=%b occ=%0d pend=%h want all zero",
               conflict, full, occupancy, pending);
    else n_pass++;
    idle();
    set_wb(1, 21, 1, 22);
    @(negedge clk);
    rstn = 1'b1;
    tick();
    idle();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_checks++;
      if (o.occ !== e.occ || o.full !== e.full || o.pend !== e.pend)
        $display("[TB] FAIL post_reset_state: got occ=%0d full=%b pend=%h want occ=%0d full=%b pend=%h",
                 o.occ, o.full, o.pend, e.occ, e.full, e.pend);
      else n_pass++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_raw();
    test_full();
    test_x0();
    test_waw();
    test_back_to_back();
    test_flush_and_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
